// File: rtl/btn_led_ctrl.sv
// Two-button LED controller: synchronised, debounced CTRL/MODE buttons drive
// four LED modes (FOLLOW, TOGGLE, COUNT, CHASE) selected by MODE presses.
module btn_led_ctrl #(
    parameter int unsigned NUM_LEDS        = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                BTN_CTRL,
    input  logic                BTN_MODE,
    output logic [NUM_LEDS-1:0] LED,
    output logic [1:0]          MODE
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam int unsigned BtnCtrl = 0;
    localparam int unsigned BtnMode = 1;

    typedef enum logic [1:0] {
        ModeFollow = 2'd0,
        ModeToggle = 2'd1,
        ModeCount  = 2'd2,
        ModeChase  = 2'd3
    } mode_e;

    logic [1:0]          btn_raw;
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          deb_q, deb_d;
    logic [1:0]          press_q, press_d;
    logic [CntW-1:0]     cnt_q [2];
    logic [CntW-1:0]     cnt_d [2];
    mode_e               mode_q, mode_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    assign btn_raw = {BTN_MODE, BTN_CTRL};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            press_q  <= press_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // The debounced level flips on the edge the count would reach DEBOUNCE_CYCLES;
    // a press pulse is raised on that same edge only for a 0->1 flip.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]   = cnt_q[i];
            deb_d[i]   = deb_q[i];
            press_d[i] = 1'b0;
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i]   = '0;
                deb_d[i]   = ~deb_q[i];
                press_d[i] = ~deb_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= ModeFollow;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
        end
    end

    // A MODE press takes priority and swallows a coincident CTRL press.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        if (press_q[BtnMode]) begin
            unique case (mode_q)
                ModeFollow: mode_d = ModeToggle;
                ModeToggle: mode_d = ModeCount;
                ModeCount:  mode_d = ModeChase;
                ModeChase:  mode_d = ModeFollow;
            endcase
            unique case (mode_d)
                ModeFollow: led_d = {NUM_LEDS{deb_q[BtnCtrl]}};
                ModeToggle: led_d = '0;
                ModeCount:  led_d = '0;
                ModeChase:  led_d = NUM_LEDS'(1);
            endcase
        end else begin
            unique case (mode_q)
                ModeFollow: led_d = {NUM_LEDS{deb_q[BtnCtrl]}};
                ModeToggle: if (press_q[BtnCtrl]) led_d = ~led_q;
                ModeCount:  if (press_q[BtnCtrl]) led_d = led_q + NUM_LEDS'(1);
                ModeChase: begin
                    if (press_q[BtnCtrl]) led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
                end
            endcase
        end
    end

    assign LED  = led_q;
    assign MODE = mode_q;

endmodule

// File: doc/btn_led_ctrl.md
BTN_LED_CTRL -- requirements
Module: btn_led_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 16, SHALL set the LED output width; legal range 2..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, SHALL set the number of consecutive stable synchronised samples needed to accept a button level; minimum 1.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port BTN_CTRL, input, 1 bit, SHALL be the raw, asynchronous action button.
REQ-006 Port BTN_MODE, input, 1 bit, SHALL be the raw, asynchronous mode-select button.
REQ-007 Port LED, output, NUM_LEDS bits, SHALL be the registered LED pattern.
REQ-008 Port MODE, output, 2 bits, SHALL be the registered current mode (0 FOLLOW, 1 TOGGLE, 2 COUNT, 3 CHASE).

Function
REQ-009 Each button SHALL pass through its own 2-flop synchroniser before any other logic.
REQ-010 Each button SHALL have an independent debouncer: a counter that clears whenever the synchronised level equals the debounced level; otherwise it increments.
REQ-011 The debounced level SHALL flip, and its counter SHALL clear, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-012 A press event SHALL be a one-cycle pulse on a 0->1 transition of the debounced level; releases SHALL NOT generate events.
REQ-013 A raw input held at a new level SHALL update LED/MODE exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new level.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synchronised samples SHALL produce no event and no LED change.
REQ-015 A BTN_MODE event SHALL advance MODE 0->1->2->3->0, with wrap-around from 3 to 0.
REQ-016 On a mode change, LED SHALL load the entry pattern of the new mode in the same cycle MODE updates:
- FOLLOW: all ones if debounced BTN_CTRL is 1, else all zeros.
- TOGGLE: all zeros.
- COUNT: all zeros.
- CHASE: only bit 0 set.
REQ-017 In FOLLOW, LED SHALL equal debounced BTN_CTRL replicated to all NUM_LEDS bits, registered one cycle after the debounced level changes.
REQ-018 In TOGGLE, each BTN_CTRL event SHALL invert every LED bit.
REQ-019 In COUNT, each BTN_CTRL event SHALL increment LED as an unsigned NUM_LEDS-bit value, wrapping from all ones to zero.
REQ-020 In CHASE, each BTN_CTRL event SHALL rotate LED left by one bit, with the MSB wrapping to bit 0; LED SHALL stay one-hot.
REQ-021 If BTN_MODE and BTN_CTRL events occur in the same cycle, the mode change SHALL win and the BTN_CTRL event SHALL be discarded.
REQ-022 A held button SHALL produce exactly one event per debounced press, regardless of hold length.

Reset
REQ-023 While rst_n is 0, the following SHALL be 0 asynchronously: LED, MODE, synchroniser flops, debounced levels, debounce counters and event pulses.
REQ-024 Reset asserted mid-debounce or mid-press SHALL discard the pending state; after release, a button already held high SHALL produce one event after the full REQ-013 latency.
REQ-025 The block SHALL leave reset in FOLLOW mode with LED = 0 on the first rising edge after rst_n rises.

Verification (NUM_LEDS=16, DEBOUNCE_CYCLES=4)
REQ-026 FOLLOW: hold BTN_CTRL=1 -> LED=16'hFFFF exactly 7 edges later. Release -> LED=16'h0000 7 edges after release.
REQ-027 Bounce: pulse BTN_CTRL high for 3 cycles, then low -> LED stays 16'h0000 and MODE stays 0.
REQ-028 Mode cycling and CHASE:
- 3 BTN_MODE presses -> MODE=3, LED=16'h0001.
- 16 BTN_CTRL presses -> LED steps 0002, 0004, ... 8000, then back to 0001.
REQ-029 COUNT wrap: in MODE=2, preload via 65535 presses (or a shortened run with NUM_LEDS=4: 15 presses -> 4'hF) -> the next press gives all zeros.
REQ-030 Simultaneous events: in TOGGLE with LED=16'hFFFF, make BTN_MODE and BTN_CTRL go stable on the same edge -> MODE=2, LED=16'h0000, no toggle applied.
REQ-031 Reset mid-run: assert rst_n=0 in COUNT with LED=16'h0005 -> LED=0 and MODE=0 immediately, without waiting for a clock edge.
